// File: rtl/mont_ctrl.sv
// mont_ctrl: radix-4 Montgomery multiplication sequencer that steers an external mpadder.
// Optional build macro MONT_CTRL_PERF_CNT_EN adds a 32-bit busy-cycle counter output.
module mont_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] in_a,
    input  logic [511:0] in_b,
    input  logic [511:0] in_m,
    input  logic         cZero,
    input  logic         cOne,
    input  logic         carry,
    input  logic [513:0] trueResult,
    output logic         adder_resetn,
    output logic [511:0] B0,
    output logic [512:0] B1,
    output logic [511:0] M0,
    output logic [512:0] M1,
    output logic [513:0] subtraction,
    output logic         enableC,
    output logic         c_doubleshift,
    output logic         subtract,
    output logic [3:0]   showFluffyPonies,
    output logic [511:0] result,
    output logic         done,
    output logic         error
`ifdef MONT_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]  cycles
`endif
);

    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, PROP, SUB, FIN} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [511:0] r_a;
    logic [511:0] r_b;
    logic [511:0] r_m;
    logic [7:0]   r_i;
    logic [2:0]   r_chunk;
    logic [1:0]   r_pass;
    logic [511:0] r_result;
    logic         r_error;
    logic         r_adder_resetn;

    logic         w_accept;
    logic         w_last_chunk;
    logic         w_a0;
    logic         w_a1;
    logic         w_q0;
    logic         w_q1;
    logic [1:0]   w_t;
    logic [1:0]   w_t2;
    logic         w_unused_hi;

    assign w_accept     = (r_state == IDLE) && start && !rst;
    assign w_last_chunk = (r_chunk == 3'd5);

    // Current radix-4 digit of A and the quotient digit that zeroes the low two bits of C.
    assign w_a0 = r_a[{r_i, 1'b0}];
    assign w_a1 = r_a[{r_i, 1'b1}];
    assign w_t  = {cOne, cZero} + (w_a0 ? r_b[1:0] : 2'b00) + (w_a1 ? {r_b[0], 1'b0} : 2'b00);
    assign w_q0 = w_t[0];
    assign w_t2 = w_t + (w_q0 ? r_m[1:0] : 2'b00);
    assign w_q1 = w_t2[1];

    assign subtraction  = ~{2'b00, r_m} + 514'd1;
    assign adder_resetn = r_adder_resetn;
    assign result       = r_result;
    assign error        = r_error;
    assign w_unused_hi  = ^trueResult[513:512];

    always_comb begin
        w_next           = r_state;
        B0               = '0;
        B1               = '0;
        M0               = '0;
        M1               = '0;
        enableC          = 1'b0;
        c_doubleshift    = 1'b0;
        subtract         = 1'b0;
        showFluffyPonies = 4'd8;
        done             = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = CLR;
            end
            CLR: begin
                w_next = ADD;
            end
            ADD: begin
                B0      = w_a0 ? r_b : '0;
                B1      = w_a1 ? {r_b, 1'b0} : '0;
                M0      = w_q0 ? r_m : '0;
                M1      = w_q1 ? {r_m, 1'b0} : '0;
                enableC = 1'b1;
                w_next  = SHIFT;
            end
            SHIFT: begin
                c_doubleshift = 1'b1;
                w_next        = (r_i == 8'd255) ? PROP : ADD;
            end
            PROP: begin
                showFluffyPonies = {1'b0, r_chunk};
                if (w_last_chunk) w_next = SUB;
            end
            SUB: begin
                subtract         = 1'b1;
                showFluffyPonies = {1'b0, r_chunk};
                // A fourth pass without carry means the subtract never settled.
                if (carry || (w_last_chunk && r_pass == 2'd3)) w_next = FIN;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_i            <= 8'd0;
            r_chunk        <= 3'd0;
            r_pass         <= 2'd0;
            r_result       <= '0;
            r_error        <= 1'b0;
            r_adder_resetn <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_adder_resetn <= (w_next != CLR);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i     <= 8'd0;
                        r_chunk <= 3'd0;
                        r_pass  <= 2'd0;
                        r_error <= 1'b0;
                    end
                end
                SHIFT: r_i <= r_i + 8'd1;
                PROP: begin
                    r_chunk <= w_last_chunk ? 3'd0 : r_chunk + 3'd1;
                    r_pass  <= 2'd0;
                end
                SUB: begin
                    r_chunk <= w_last_chunk ? 3'd0 : r_chunk + 3'd1;
                    if (w_last_chunk) r_pass <= r_pass + 2'd1;
                    if (!carry && w_last_chunk && r_pass == 2'd3) r_error <= 1'b1;
                end
                FIN: r_result <= trueResult[511:0];
                default: ;
            endcase
        end
    end

    // Operands need no reset; they are only consumed after an accepted start.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
            r_m <= in_m;
        end
    end

`ifdef MONT_CTRL_PERF_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= 32'd0;
        end else if (w_accept) begin
            r_cycles <= 32'd0;
        end else if (r_state != IDLE) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_mont_ctrl.sv
// Self-checking bench for mont_ctrl with a behavioural mpadder and an expected-result scoreboard.
`timescale 1ns/1ps
module tb_mont_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] in_a;
    logic [511:0] in_b;
    logic [511:0] in_m;
    logic         cZero;
    logic         cOne;
    logic         carry;
    logic [513:0] trueResult;
    logic         adder_resetn;
    logic [511:0] B0;
    logic [512:0] B1;
    logic [511:0] M0;
    logic [512:0] M1;
    logic [513:0] subtraction;
    logic         enableC;
    logic         c_doubleshift;
    logic         subtract;
    logic [3:0]   showFluffyPonies;
    logic [511:0] result;
    logic         done;
    logic         error;
`ifdef MONT_CTRL_PERF_CNT_EN
    logic [31:0]  cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mont_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .cZero(cZero), .cOne(cOne), .carry(carry), .trueResult(trueResult),
        .adder_resetn(adder_resetn),
        .B0(B0), .B1(B1), .M0(M0), .M1(M1),
        .subtraction(subtraction),
        .enableC(enableC), .c_doubleshift(c_doubleshift), .subtract(subtract),
        .showFluffyPonies(showFluffyPonies),
        .result(result), .done(done), .error(error)
`ifdef MONT_CTRL_PERF_CNT_EN
        , .cycles(cycles)
`endif
    );

    // Behavioural mpadder: plain-integer accumulator, copied into the result register
    // at the end of PROP, and reduced by M at the end of each SUB pass while nonnegative.
    logic [515:0] mdl_c;
    logic [513:0] mdl_r;
    logic [513:0] mdl_diff;
    logic         force_nc = 1'b0;

    assign mdl_diff   = mdl_r + subtraction;
    assign cZero      = mdl_c[0];
    assign cOne       = mdl_c[1];
    assign trueResult = mdl_r;
    assign carry      = !force_nc && subtract && (showFluffyPonies == 4'd5) && mdl_diff[513];

    always @(posedge clk) begin
        if (!adder_resetn) mdl_c <= '0;
        else if (enableC) mdl_c <= mdl_c + 516'(B0) + 516'(B1) + 516'(M0) + 516'(M1);
        else if (c_doubleshift) mdl_c <= mdl_c >> 2;
        if (showFluffyPonies == 4'd5) begin
            if (!subtract) mdl_r <= mdl_c[513:0];
            else if (!mdl_diff[513]) mdl_r <= mdl_diff;
        end
    end

    int n_en = 0, n_ds = 0, n_coinc = 0, n_pony_bad = 0, n_sub = 0, n_done = 0;
    always @(negedge clk) begin
        if (enableC) n_en++;
        if (c_doubleshift) n_ds++;
        if (enableC && c_doubleshift) n_coinc++;
        if ((enableC || c_doubleshift) && showFluffyPonies != 4'd8) n_pony_bad++;
        if (subtract) n_sub++;
        if (done) n_done++;
    end

    typedef struct packed {
        logic [511:0] res;
        logic         err;
    } exp_t;
    exp_t sb_q[$];

    // Golden A*B*2^-512 mod M: plain modular product, then 512 exact halvings mod M.
    function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m);
        logic [513:0] r;
        r = '0;
        for (int k = 511; k >= 0; k--) begin
            r = r << 1;
            if (r >= {2'b00, m}) r = r - {2'b00, m};
            if (a[k]) begin
                r = r + {2'b00, b};
                if (r >= {2'b00, m}) r = r - {2'b00, m};
            end
        end
        for (int k = 0; k < 512; k++) begin
            if (r[0]) r = r + {2'b00, m};
            r = r >> 1;
        end
        return r[511:0];
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_start(input logic [511:0] a, input logic [511:0] b,
                               input logic [511:0] m, input logic err);
        exp_t e;
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        e.res = mont_ref(a, b, m);
        e.err = err;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output logic timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        in_m  = '0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
        checks++; if (enableC !== 1'b0 || c_doubleshift !== 1'b0 || subtract !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got en=%0b ds=%0b sub=%0b want 0 0 0", enableC, c_doubleshift, subtract); end
        checks++; if (showFluffyPonies !== 4'd8) begin errors++; $display("FAIL reset_pony: got %0d want 8", showFluffyPonies); end
        checks++; if (adder_resetn !== 1'b0) begin errors++; $display("FAIL reset_adder_resetn: got %0b want 0", adder_resetn); end
        checks++; if (B0 !== '0 || B1 !== '0 || M0 !== '0 || M1 !== '0) begin
            errors++; $display("FAIL reset_addends: got nonzero B0/B1/M0/M1 want all 0"); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
`ifdef MONT_CTRL_PERF_CNT_EN
        checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++; if (adder_resetn !== 1'b1) begin errors++; $display("FAIL release_adder_resetn: got %0b want 1", adder_resetn); end
    endtask

    task automatic test_small();
        logic to;
        exp_t e;
        int   base_done;
        base_done = n_done;
        drive_start(512'd1, 512'd1, 512'd3, 1'b0);
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL small_timeout: got no done want done"); end
        e = '0;
        checks++; if (sb_q.size() != 1) begin errors++; $display("FAIL small_queue: got %0d entries want 1", sb_q.size()); end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++; if (error !== e.err) begin errors++; $display("FAIL small_error: got %0b want %0b", error, e.err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL small_done_width: got %0b want 0", done); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL small_result: got %h want %h", result, e.res); end
        checks++; if (result !== 512'd1) begin errors++; $display("FAIL small_result_one: got %h want 1", result); end
        checks++; if (n_done - base_done != 1) begin errors++; $display("FAIL small_done_count: got %0d want 1", n_done - base_done); end
    endtask

    task automatic test_golden();
        logic [511:0] m;
        logic to;
        exp_t e;
        int   base_sub, sub;
        m = '0;
        m[511] = 1'b1;
        m[0] = 1'b1;
        base_sub = n_sub;
        drive_start(m - 512'd1, m - 512'd1, m, 1'b0);
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL golden_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL golden_error: got %0b want 0", error); end
        @(negedge clk);
        checks++; if (result !== e.res) begin errors++; $display("FAIL golden_result: got %h want %h", result, e.res); end
        sub = n_sub - base_sub;
        checks++; if (sub != 6 && sub != 12) begin errors++; $display("FAIL golden_sub_cycles: got %0d want 6 or 12", sub); end
`ifdef MONT_CTRL_PERF_CNT_EN
        checks++; if (cycles !== 32'(520 + sub)) begin errors++; $display("FAIL golden_cycles: got %0d want %0d", cycles, 520 + sub); end
        repeat (3) @(negedge clk);
        checks++; if (cycles !== 32'(520 + sub)) begin errors++; $display("FAIL golden_cycles_hold: got %0d want %0d", cycles, 520 + sub); end
`endif
    endtask

    task automatic test_loop();
        logic [511:0] m, a, b;
        logic to;
        exp_t e;
        int   b_en, b_ds, b_co, b_pb;
        m = rnd512(); m[511] = 1'b1; m[0] = 1'b1;
        a = rnd512(); a[511] = 1'b0;
        b = rnd512(); b[511] = 1'b0;
        b_en = n_en; b_ds = n_ds; b_co = n_coinc; b_pb = n_pony_bad;
        drive_start(a, b, m, 1'b0);
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL loop_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        @(negedge clk);
        checks++; if (result !== e.res) begin errors++; $display("FAIL loop_result: got %h want %h", result, e.res); end
        checks++; if (n_en - b_en != 256) begin errors++; $display("FAIL loop_enableC: got %0d want 256", n_en - b_en); end
        checks++; if (n_ds - b_ds != 256) begin errors++; $display("FAIL loop_doubleshift: got %0d want 256", n_ds - b_ds); end
        checks++; if (n_coinc - b_co != 0) begin errors++; $display("FAIL loop_coincident: got %0d want 0", n_coinc - b_co); end
        checks++; if (n_pony_bad - b_pb != 0) begin errors++; $display("FAIL loop_pony: got %0d non-8 cycles want 0", n_pony_bad - b_pb); end
    endtask

    task automatic test_ignore_start();
        logic [511:0] m, a, b;
        logic to, seen;
        exp_t e;
        int   b_done, b_en;
        m = rnd512(); m[511] = 1'b1; m[0] = 1'b1;
        a = rnd512(); a[511] = 1'b0;
        b = rnd512(); b[511] = 1'b0;
        b_done = n_done; b_en = n_en;
        drive_start(a, b, m, 1'b0);
        // SHIFT
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); seen = c_doubleshift; end
        checks++; if (!seen) begin errors++; $display("FAIL ignore_wait_shift: got timeout want SHIFT"); end
        in_a = rnd512(); in_b = rnd512(); in_m = rnd512() | 512'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        // PROP
        seen = 1'b0;
        for (int k = 0; k < 700 && !seen; k++) begin @(negedge clk); seen = (showFluffyPonies != 4'd8) && !subtract; end
        checks++; if (!seen) begin errors++; $display("FAIL ignore_wait_prop: got timeout want PROP"); end
        in_a = rnd512(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        // SUB
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = subtract; end
        checks++; if (!seen) begin errors++; $display("FAIL ignore_wait_sub: got timeout want SUB"); end
        in_b = rnd512(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ignore_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        @(negedge clk);
        checks++; if (result !== e.res) begin errors++; $display("FAIL ignore_result: got %h want %h", result, e.res); end
        repeat (20) @(negedge clk);
        checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", n_done - b_done); end
        checks++; if (n_en - b_en != 256) begin errors++; $display("FAIL ignore_restart: got %0d enableC want 256", n_en - b_en); end
    endtask

    task automatic test_rst_mid();
        logic [511:0] m, a, b;
        logic to;
        exp_t e;
        int   k_ds, b_done;
        m = rnd512(); m[511] = 1'b1; m[0] = 1'b1;
        a = rnd512(); a[511] = 1'b0;
        b = rnd512(); b[511] = 1'b0;
        b_done = n_done;
        drive_start(a, b, m, 1'b0);
        k_ds = 0;
        for (int k = 0; k < 400 && k_ds < 100; k++) begin @(negedge clk); if (c_doubleshift) k_ds++; end
        checks++; if (k_ds != 100) begin errors++; $display("FAIL rstmid_wait: got %0d shifts want 100", k_ds); end
        @(negedge clk);
        checks++; if (enableC !== 1'b1) begin errors++; $display("FAIL rstmid_in_add: got enableC=%0b want 1", enableC); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (adder_resetn !== 1'b0) begin errors++; $display("FAIL rstmid_adder_resetn: got %0b want 0", adder_resetn); end
        checks++; if (enableC !== 1'b0 || c_doubleshift !== 1'b0 || showFluffyPonies !== 4'd8 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got en=%0b ds=%0b pony=%0d done=%0b want 0 0 8 0", enableC, c_doubleshift, showFluffyPonies, done); end
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_done - b_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", n_done - b_done); end
        a = rnd512(); a[511] = 1'b0;
        drive_start(a, b, m, 1'b0);
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        @(negedge clk);
        checks++; if (result !== e.res) begin errors++; $display("FAIL rstmid_result: got %h want %h", result, e.res); end
    endtask

    task automatic test_error();
        logic [511:0] m, a, b;
        logic to;
        exp_t e;
        int   b_sub;
        m = rnd512(); m[511] = 1'b1; m[0] = 1'b1;
        a = rnd512(); a[511] = 1'b0;
        b = rnd512(); b[511] = 1'b0;
        force_nc = 1'b1;
        b_sub = n_sub;
        drive_start(a, b, m, 1'b1);
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL error_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++; if (error !== e.err) begin errors++; $display("FAIL error_flag: got %0b want %0b", error, e.err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL error_done_width: got %0b want 0", done); end
        checks++; if (n_sub - b_sub != 24) begin errors++; $display("FAIL error_sub_cycles: got %0d want 24", n_sub - b_sub); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_hold: got %0b want 1", error); end
        force_nc = 1'b0;
        drive_start(b, a, m, 1'b0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_clear: got %0b want 0", error); end
        wait_done(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL error_next_timeout: got no done want done"); end
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        checks++; if (error !== e.err) begin errors++; $display("FAIL error_next_flag: got %0b want %0b", error, e.err); end
        @(negedge clk);
        checks++; if (result !== e.res) begin errors++; $display("FAIL error_next_result: got %h want %h", result, e.res); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_golden();
        test_loop();
        test_ignore_start();
        test_rst_mid();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mont_ctrl.md
MONT_CTRL -- requirements
Module: mont_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The module SHALL have port start, input, 1 bit: one-cycle request, sampled only in IDLE.
REQ-004 The module SHALL have ports in_a, in_b, in_m, each input, 512 bits: operands; in_m odd, all operands < in_m.
REQ-005 The module SHALL have port cZero, input, 1 bit, and port cOne, input, 1 bit: bits 0 and 1 of the carry-save accumulator C from mpadder.
REQ-006 The module SHALL have port carry, input, 1 bit: subtract-finished from mpadder.
REQ-007 The module SHALL have port trueResult, input, 514 bits: mpadder result register.
REQ-008 The module SHALL have port adder_resetn, output, 1 bit: active-low clear for mpadder.
REQ-009 The module SHALL have ports B0 (output, 512 bits), B1 (output, 513 bits), M0 (output, 512 bits) and M1 (output, 513 bits): mpadder addends.
REQ-010 The module SHALL have port subtraction, output, 514 bits: two's complement of in_m, sign-extended to 514 bits.
REQ-011 The module SHALL have ports enableC, c_doubleshift and subtract, each output, 1 bit: mpadder controls.
REQ-012 The module SHALL have port showFluffyPonies, output, 4 bits: mpadder chunk selector.
REQ-013 The module SHALL have ports result (output, 512 bits), done (output, 1 bit) and error (output, 1 bit).

Function
REQ-014 The FSM SHALL have states IDLE, CLR, ADD, SHIFT, PROP, SUB and FIN; only IDLE accepts start.
REQ-015 On start in IDLE, the block SHALL latch in_a, in_b and in_m, clear digit counter i (8 bits), and go to CLR.
REQ-016 In CLR, the block SHALL drive adder_resetn=0 for exactly 1 cycle, then go to ADD.
REQ-017 In ADD, the block SHALL set a0=A[2i] and a1=A[2i+1], and drive B0 = a0 ? B : 0 and B1 = a1 ? {B,1'b0} : 0.
REQ-018 In ADD, the block SHALL compute t = {cOne,cZero} + a0*B[1:0] + a1*{B[0],0} mod 4, then q0 = t[0] and q1 = (t + q0*M[1:0])[1].
REQ-019 In ADD, the block SHALL drive M0 = q0 ? M : 0 and M1 = q1 ? {M,1'b0} : 0, and pulse enableC for 1 cycle.
REQ-020 In SHIFT, the block SHALL pulse c_doubleshift for 1 cycle, with B0, B1, M0 and M1 at 0.
REQ-021 After SHIFT, the block SHALL increment i and return to ADD; when i wraps from 255 to 0, it SHALL go to PROP instead; the loop takes 512 cycles.
REQ-022 In PROP, showFluffyPonies SHALL step 0,1,2,3,4,5 over 6 cycles with subtract=0, and the block SHALL then go to SUB.
REQ-023 In SUB, the block SHALL hold subtract=1 and cycle showFluffyPonies 0..5 repeatedly; each 6-cycle sequence is one pass.
REQ-024 In SUB, if carry=1 in any cycle, the block SHALL finish the current cycle and go to FIN.
REQ-025 In SUB, if 4 passes complete without carry, the block SHALL set error=1 and go to FIN.
REQ-026 In FIN, the block SHALL register result <= trueResult[511:0], pulse done for 1 cycle, and return to IDLE.
REQ-027 Outside PROP and SUB, showFluffyPonies SHALL be 4'd8, which freezes the mpadder operand pipeline.
REQ-028 enableC and c_doubleshift SHALL never be high in the same cycle.
REQ-029 A start arriving outside IDLE SHALL be ignored with no side effect; start and done in the same cycle SHALL be impossible.
REQ-030 error SHALL clear on the next accepted start; result SHALL hold its value until the next FIN.

Reset
REQ-031 When rst=1, the FSM SHALL enter IDLE, i=0, result=0, and done, error, enableC, c_doubleshift and subtract SHALL be 0.
REQ-032 When rst=1, showFluffyPonies SHALL be 8, adder_resetn SHALL be 0, and B0, B1, M0 and M1 SHALL be 0.
REQ-033 adder_resetn SHALL go to 1 on the first cycle after rst deasserts.
REQ-034 rst asserted mid-operation SHALL abort the operation with no done pulse and return all outputs to reset values on the next edge.

Configuration
REQ-035 With MONT_CTRL_PERF_CNT_EN defined, the block SHALL add output cycles (32 bits): cleared on accepted start, +1 every non-IDLE cycle, held after done, reset to 0.
REQ-036 Without MONT_CTRL_PERF_CNT_EN, the port and the counter SHALL be absent, with no other behavioural change.

Verification
REQ-037 Scenario: A=1, B=1, M=3 with a behavioural mpadder model -> result=1, done 1 cycle, error=0.
REQ-038 Scenario: A=B=M-1 with M=2^511+1 -> result equals the golden model (A*B*2^-512 mod M); with MONT_CTRL_PERF_CNT_EN, cycles = 1+512+6+6k+1 for k subtract passes.
REQ-039 Scenario: monitor the ADD/SHIFT loop -> exactly 256 enableC pulses and 256 c_doubleshift pulses, never coincident, and showFluffyPonies=8 throughout.
REQ-040 Scenario: start pulsed in SHIFT, PROP and SUB -> ignored, latched operands unchanged, single done.
REQ-041 Scenario: rst at digit i=100 -> next cycle state IDLE and adder_resetn=0; after rst release, a new start gives the correct result.
REQ-042 Scenario: mpadder model forced to carry=0 -> error=1 after 4 passes (24 SUB cycles), done pulses, and the next start clears error.
